// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C bus arbiter.
// Holds the arbiter state encoding and the default byte/address widths.
package i2c_pkg;

    localparam int I2C_DATA_WIDTH = 8;
    localparam int I2C_ADDR_WIDTH = I2C_DATA_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        LAUNCH = 3'd2,
        BUSY   = 3'd3,
        GAP    = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Searches i_req starting one position after i_ptr, wrapping around, and
// returns the first set request as a one-hot grant plus its index.
// o_gnt is all-zero when no request is set.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx
);

    int   w_k;
    logic w_found;

    // First set request after the pointer, with wrap-around
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_k = (int'(i_ptr) + i) % NUM_REQ;
            if (!w_found && i_req[w_k]) begin
                w_found    = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx      = IDX_W'(w_k);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NUM_REQ requesters.
// Latches the winner's address/data/direction, holds the master enabled for
// one transfer, returns read data and status to the winner, then enforces a
// bus-free gap of GAP_CYCLES clocks before the next arbitration.
// Optional feature macro: I2C_ARB_TIMEOUT_EN adds a BUSY watchdog that ends
// a stalled transfer with err_o=1 once a TMO_WIDTH counter reaches all-ones.
// Handshake: req_i is a level held by the requester; the winner sees gnt_o
// from LAUNCH to the end of BUSY and exactly one done_o cycle per transfer.
// The master sees a level m_en_o and answers with a one-cycle m_done_i.
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = I2C_DATA_WIDTH,
    parameter int PRESC_WIDTH = 16,
    parameter int GAP_CYCLES  = 64,
    parameter int TMO_WIDTH   = 20,
    localparam int ADDR_WIDTH = DATA_WIDTH - 1
) (
    input  logic                          clk_i,
    input  logic                          a_rst_n_i,
    input  logic [PRESC_WIDTH-1:0]        prescale_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_REQ-1:0]            dir_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          err_o,
    output logic                          m_en_o,
    output logic [ADDR_WIDTH-1:0]         m_slave_addr_o,
    output logic [DATA_WIDTH-1:0]         m_data_o,
    output logic                          m_dir_o,
    output logic [PRESC_WIDTH-1:0]        m_prescale_o,
    input  logic                          m_done_i,
    input  logic                          m_ack_err_i,
    input  logic [DATA_WIDTH-1:0]         m_rdata_i,
    output arb_state_t                    o_dbg_state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    arb_state_t              r_state;
    arb_state_t              w_next;
    logic [IDX_W-1:0]        r_ptr;
    logic [NUM_REQ-1:0]      r_gnt;
    logic                    r_m_en;
    logic [ADDR_WIDTH-1:0]   r_m_addr;
    logic [DATA_WIDTH-1:0]   r_m_data;
    logic                    r_m_dir;
    logic [NUM_REQ-1:0]      r_done;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic [NUM_REQ-1:0]      w_gnt;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_req_any;
    logic                    w_gap_end;
    logic                    w_tmo_hit;

    assign w_req_any = |req_i;
    assign w_gap_end = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req (req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

`ifdef I2C_ARB_TIMEOUT_EN
    logic [TMO_WIDTH-1:0] r_tmo;

    // BUSY watchdog: counts BUSY cycles 1-based, so all-ones is reached at
    // the end of the (2^TMO_WIDTH-1)th BUSY cycle
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            r_tmo <= '0;
        end else if (r_state == LAUNCH) begin
            r_tmo <= TMO_WIDTH'(1);
        end else if (r_state == BUSY) begin
            r_tmo <= r_tmo + TMO_WIDTH'(1);
        end else begin
            r_tmo <= '0;
        end
    end

    assign w_tmo_hit = (r_state == BUSY) && (&r_tmo);
`else
    assign w_tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; an ARB cycle with all requests withdrawn aborts
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_req_any) w_next = ARB;
            ARB:     w_next = w_req_any ? LAUNCH : IDLE;
            LAUNCH:  w_next = BUSY;
            BUSY:    if (m_done_i || w_tmo_hit) w_next = GAP;
            GAP:     if (w_gap_end) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Transfer datapath: latch winner in ARB, report completion out of BUSY
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            r_ptr    <= IDX_W'(NUM_REQ - 1);
            r_gnt    <= '0;
            r_m_en   <= 1'b0;
            r_m_addr <= '0;
            r_m_data <= '0;
            r_m_dir  <= 1'b0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ARB: begin
                    if (w_req_any) begin
                        r_m_addr <= addr_i[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        r_m_data <= wdata_i[w_idx*DATA_WIDTH +: DATA_WIDTH];
                        r_m_dir  <= dir_i[w_idx];
                        r_ptr    <= w_idx;
                        r_gnt    <= w_gnt;
                        r_m_en   <= 1'b1;
                    end
                end
                BUSY: begin
                    if (m_done_i) begin
                        r_done <= r_gnt;
                        r_err  <= m_ack_err_i;
                        if (r_m_dir) begin
                            r_rdata <= m_rdata_i;
                        end
                        r_gnt  <= '0;
                        r_m_en <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_done <= r_gnt;
                        r_err  <= 1'b1;
                        r_gnt  <= '0;
                        r_m_en <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus-free gap counter, runs only while in GAP
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            r_gap_cnt <= '0;
        end else if (r_state == GAP) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end else begin
            r_gap_cnt <= '0;
        end
    end

    assign gnt_o          = r_gnt;
    assign done_o         = r_done;
    assign rdata_o        = r_rdata;
    assign err_o          = r_err;
    assign m_en_o         = r_m_en;
    assign m_slave_addr_o = r_m_addr;
    assign m_data_o       = r_m_data;
    assign m_dir_o        = r_m_dir;
    assign m_prescale_o   = prescale_i;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Testbench for i2c_bus_arbiter: a table of transfers (request mask,
// direction, master response, expected winner and latency) followed by
// hand-written sequences for withdraw, spurious done, ARB abort and reset.
module tb_i2c_bus_arbiter;
    import i2c_pkg::*;

    localparam int GAP      = 8;
    localparam int LAT_IDLE = 2;        // req seen in IDLE -> m_en_o two cycles later
    localparam int LAT_B2B  = GAP + 1;  // m_en_o low GAP+2 cycles; one spent on the pulse check

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] prescale = '0;
    logic [3:0]  req = '0;
    logic [27:0] addr;
    logic [31:0] wdata;
    logic [3:0]  dir = '0;
    logic [3:0]  gnt, done;
    logic [7:0]  rdata;
    logic        err, m_en, m_dir;
    logic [6:0]  m_addr;
    logic [7:0]  m_data;
    logic [15:0] m_presc;
    logic        m_done = 1'b0;
    logic        m_ack = 1'b0;
    logic [7:0]  m_rdata = '0;
    arb_state_t  dbg_state;

    logic [6:0]  addr_tab [4] = '{7'h50, 7'h51, 7'h52, 7'h53};
    logic [7:0]  wdata_tab[4] = '{8'hA5, 8'hB1, 8'hC2, 8'hD3};

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [7:0]  exp_rdata = '0;
    logic [3:0]  exp_q[$];

    typedef struct {
        logic [3:0] req;
        logic [3:0] dir;
        logic       ack;
        logic [7:0] rd;
        int         exp_idx;
        bit         settle;
        int         exp_wait;
        int         busy;
        logic [3:0] req_after;
    } vec_t;

    vec_t vecs[17];

    i2c_bus_arbiter #(
        .NUM_REQ     (4),
        .DATA_WIDTH  (8),
        .PRESC_WIDTH (16),
        .GAP_CYCLES  (GAP),
        .TMO_WIDTH   (8)
    ) dut (
        .clk_i          (clk),
        .a_rst_n_i      (rst_n),
        .prescale_i     (prescale),
        .req_i          (req),
        .addr_i         (addr),
        .wdata_i        (wdata),
        .dir_i          (dir),
        .gnt_o          (gnt),
        .done_o         (done),
        .rdata_o        (rdata),
        .err_o          (err),
        .m_en_o         (m_en),
        .m_slave_addr_o (m_addr),
        .m_data_o       (m_data),
        .m_dir_o        (m_dir),
        .m_prescale_o   (m_presc),
        .m_done_i       (m_done),
        .m_ack_err_i    (m_ack),
        .m_rdata_i      (m_rdata),
        .o_dbg_state    (dbg_state)
    );

    // Clock and packed per-requester operands
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            addr[k*7 +: 7]  = addr_tab[k];
            wdata[k*8 +: 8] = wdata_tab[k];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // One transfer: wait for launch, check the latched operands, hold BUSY,
    // answer as the master, then check the completion and its single-cycle pulse
    task automatic do_xfer(input int idx, input int exp_wait, input logic ack,
                           input logic [7:0] rd, input int busy_len,
                           input logic [3:0] req_mid, input logic [3:0] req_after,
                           input string tag);
        int         cnt;
        logic [3:0] exp_g;
        logic [3:0] one;
        cnt = 0;
        one = 4'(1 << idx);
        while (m_en !== 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        check({tag, "_m_en"}, 32'(m_en), 32'(1));
        if (exp_wait != 0) check({tag, "_lat"}, cnt, exp_wait);
        exp_g = exp_q.pop_front();
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
        check({tag, "_addr"}, 32'(m_addr), 32'(addr_tab[idx]));
        check({tag, "_data"}, 32'(m_data), 32'(wdata_tab[idx]));
        check({tag, "_dir"}, 32'(m_dir), 32'(dir[idx]));
        check({tag, "_st"}, 32'(dbg_state), 32'(LAUNCH));
        for (int i = 0; i < busy_len; i++) begin
            if (i == busy_len / 2) req = req_mid;
            step();
        end
        check({tag, "_hold"}, {26'(0), m_en, 1'b0, gnt}, {26'(0), 1'b1, 1'b0, one});
        m_done  = 1'b1;
        m_ack   = ack;
        m_rdata = rd;
        step();
        m_done  = 1'b0;
        m_ack   = 1'b0;
        m_rdata = 8'hEE;
        req     = req_after;
        if (dir[idx]) exp_rdata = rd;
        check({tag, "_done"}, 32'(done), 32'(one));
        check({tag, "_err"}, 32'(err), 32'(ack));
        check({tag, "_rdata"}, 32'(rdata), 32'(exp_rdata));
        check({tag, "_release"}, {27'(0), m_en, gnt}, 32'(0));
        step();
        check({tag, "_pulse"}, 32'(done), 32'(0));
    endtask

    initial begin
        vecs[0]  = '{4'b1111, 4'b0000, 1'b0, 8'h00, 0, 1'b0, LAT_IDLE, 4,   4'b1111};
        vecs[1]  = '{4'b1111, 4'b0000, 1'b0, 8'h00, 1, 1'b0, LAT_B2B,  4,   4'b1111};
        vecs[2]  = '{4'b1111, 4'b0000, 1'b0, 8'h00, 2, 1'b0, LAT_B2B,  4,   4'b1111};
        vecs[3]  = '{4'b1111, 4'b0000, 1'b0, 8'h00, 3, 1'b0, LAT_B2B,  4,   4'b1111};
        vecs[4]  = '{4'b1111, 4'b0000, 1'b0, 8'h00, 0, 1'b0, LAT_B2B,  4,   4'b1111};
        vecs[5]  = '{4'b1111, 4'b0000, 1'b0, 8'h00, 1, 1'b0, LAT_B2B,  4,   4'b1111};
        vecs[6]  = '{4'b1111, 4'b0000, 1'b0, 8'h00, 2, 1'b0, LAT_B2B,  4,   4'b1111};
        vecs[7]  = '{4'b1111, 4'b0000, 1'b0, 8'h00, 3, 1'b0, LAT_B2B,  4,   4'b0000};
        vecs[8]  = '{4'b0001, 4'b0000, 1'b0, 8'h00, 0, 1'b1, LAT_IDLE, 100, 4'b0000};
        vecs[9]  = '{4'b0100, 4'b0100, 1'b0, 8'h3C, 2, 1'b1, LAT_IDLE, 6,   4'b0000};
        vecs[10] = '{4'b0010, 4'b0000, 1'b0, 8'hFF, 1, 1'b1, LAT_IDLE, 5,   4'b0000};
        vecs[11] = '{4'b1000, 4'b0000, 1'b1, 8'h00, 3, 1'b1, LAT_IDLE, 5,   4'b0000};
        vecs[12] = '{4'b1000, 4'b0000, 1'b0, 8'h00, 3, 1'b1, LAT_IDLE, 5,   4'b0000};
        vecs[13] = '{4'b1001, 4'b0000, 1'b0, 8'h00, 0, 1'b1, LAT_IDLE, 5,   4'b1001};
        vecs[14] = '{4'b1001, 4'b0000, 1'b0, 8'h00, 3, 1'b0, LAT_B2B,  5,   4'b0000};
        vecs[15] = '{4'b0110, 4'b0100, 1'b1, 8'h5A, 1, 1'b1, LAT_IDLE, 5,   4'b0110};
        vecs[16] = '{4'b0110, 4'b0100, 1'b0, 8'h5A, 2, 1'b0, LAT_B2B,  5,   4'b0000};

        // Reset state
        repeat (3) step();
        check("rst_outs", {gnt, done, rdata, 7'(0), err, m_en, m_dir}, 32'(0));
        check("rst_maddr", 32'(m_addr), 32'(0));
        check("rst_mdata", 32'(m_data), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        prescale = 16'h1234;
        #1 check("presc_a", 32'(m_presc), 32'h1234);
        @(negedge clk) rst_n = 1'b1;
        step();
        prescale = 16'hBEEF;
        #1 check("presc_b", 32'(m_presc), 32'hBEEF);

        // Table of transfers
        for (int v = 0; v < 17; v++) begin
            dir = vecs[v].dir;
            if (vecs[v].settle) repeat (GAP + 1) step();
            req = vecs[v].req;
            exp_q.push_back(4'(1 << vecs[v].exp_idx));
            do_xfer(vecs[v].exp_idx, vecs[v].exp_wait, vecs[v].ack, vecs[v].rd,
                    vecs[v].busy, vecs[v].req, vecs[v].req_after, $sformatf("v%0d", v));
        end

        // Requester 1 withdraws mid-BUSY: transfer still completes (ptr 2 -> winner 1)
        dir = 4'b0000;
        repeat (GAP + 1) step();
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        do_xfer(1, LAT_IDLE, 1'b0, 8'h11, 10, 4'b0000, 4'b0000, "withdraw");

        // Spurious m_done_i in IDLE is ignored
        repeat (GAP + 1) step();
        check("spur_idle", 32'(dbg_state), 32'(IDLE));
        m_done = 1'b1; m_ack = 1'b1; m_rdata = 8'h77;
        step();
        m_done = 1'b0; m_ack = 1'b0;
        check("spur_done", 32'(done), 32'(0));
        check("spur_err", 32'(err), 32'(0));
        check("spur_rdata", 32'(rdata), 32'(exp_rdata));

        // Request gone during ARB: back to IDLE, no grant, pointer kept at 1
        req = 4'b0001;
        step();
        check("abort_arb", 32'(dbg_state), 32'(ARB));
        req = 4'b0000;
        step();
        check("abort_idle", 32'(dbg_state), 32'(IDLE));
        check("abort_nogrant", {27'(0), m_en, gnt}, 32'(0));
        req = 4'b1111;
        exp_q.push_back(4'b0100);
        do_xfer(2, LAT_IDLE, 1'b0, 8'h00, 4, 4'b1111, 4'b0000, "after_abort");

        // Asynchronous reset while BUSY
        repeat (GAP + 1) step();
        req = 4'b0001;
        repeat (LAT_IDLE) step();
        check("rb_gnt", 32'(gnt), 32'(4'b0001));
        repeat (3) step();
        check("rb_busy", 32'(dbg_state), 32'(BUSY));
        #3 rst_n = 1'b0;
        #1;
        check("rb_async", {26'(0), err, m_en, gnt}, 32'(0));
        check("rb_state", 32'(dbg_state), 32'(IDLE));
        check("rb_maddr", 32'(m_addr), 32'(0));
        req = 4'b1000;
        exp_rdata = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        exp_q.push_back(4'b1000);
        do_xfer(3, LAT_IDLE, 1'b0, 8'h00, 4, 4'b1000, 4'b0000, "after_rst");

`ifdef I2C_ARB_TIMEOUT_EN
        // Withheld m_done_i: 1 LAUNCH cycle + 255 BUSY cycles, then done with error
        begin
            int cnt;
            repeat (GAP + 1) step();
            req = 4'b0100;
            repeat (LAT_IDLE) step();
            check("tmo_gnt", 32'(gnt), 32'(4'b0100));
            cnt = 0;
            while (done === 4'b0000 && cnt < 400) begin
                step();
                cnt++;
            end
            req = 4'b0000;
            check("tmo_cycles", cnt, 256);
            check("tmo_done", 32'(done), 32'(4'b0100));
            check("tmo_err", 32'(err), 32'(1));
            check("tmo_rdata", 32'(rdata), 32'(exp_rdata));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
